axi_interconnect_rd: RTL
========================

Name: axi_interconnect_rd

Overview:
- Read-side counterpart of the multi-channel AXI write interconnect.
- Arbitrates burst read requests from CH_NUM video output channels using round-robin.
- Issues one AXI read burst per grant and steers the returned beats into the granted channel's display FIFO.
- Keeps a per-channel frame address pointer that wraps at frame end; sits between the DDR AXI read port and the per-channel output FIFOs.

Parameters:
- CH_NUM, 5: number of read channels (channel index 0..CH_NUM-1).
- DATA_W, 256: AXI read data width.
- ADDR_W, 28: AXI byte address width.
- BURST_LEN, 16: beats per burst; axi_arlen = BURST_LEN-1.
- CH_BASE_STEP, 28'h0400000: byte offset between consecutive channel frame buffers.
- FRAME_BURSTS, 8100: bursts per frame (1920x1080x16b / 512 B).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ch_rd_req  in  CH_NUM  level; bit i high = FIFO i has room for one full burst.
- ch_frame_sync  in  CH_NUM  1-cycle pulse; restart channel i at frame start.
- ch_wr_en  out  CH_NUM  one-hot FIFO write strobe.
- ch_wr_data  out  DATA_W  shared FIFO write data.
- ch_frame_done  out  CH_NUM  1-cycle pulse when channel i's last burst of the frame completes.
- axi_araddr  out  ADDR_W  read address.
- axi_arlen  out  8  constant BURST_LEN-1.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_rdata  in  DATA_W  read data.
- axi_rvalid  in  1  read data valid.
- axi_rlast  in  1  last beat of burst.
- axi_rready  out  1  read data ready.
- busy  out  1  high in any state other than IDLE.
- burst_err  out  1  sticky; set on beat-count mismatch.

Behaviour:
- Reset: every output 0 except axi_arlen (constant); state IDLE; rr_ptr=0; all burst counters 0; pending syncs cleared. Reset during a burst abandons it; the slave-side cleanup is not this block's responsibility.
- FSM states: IDLE, ARB, ADDR, DATA, DONE.
- IDLE: if any ch_rd_req bit is high, go to ARB next cycle.
- ARB (1 cycle):
  - grant = first set request bit scanning rr_ptr, rr_ptr+1, ... modulo CH_NUM.
  - Register axi_araddr = grant*CH_BASE_STEP + burst_cnt[grant]*(BURST_LEN*DATA_W/8), truncated to ADDR_W.
  - If the requests have dropped meanwhile, return to IDLE.
- ADDR: axi_arvalid=1 with axi_araddr stable until the cycle axi_arready=1. Handshake cycle: arvalid drops next cycle; go to DATA.
- DATA:
  - axi_rready=1 throughout; the requester guarantees FIFO space.
  - Each cycle with rvalid: ch_wr_en[grant]=1 and ch_wr_data=axi_rdata, registered (1-cycle latency); beat_cnt increments.
  - Beat with rvalid & rlast: go to DONE; axi_rready drops next cycle.
- DONE (1 cycle):
  - If beat count != BURST_LEN (early or missing rlast), set burst_err.
  - burst_cnt[grant] increments; if it equals FRAME_BURSTS-1, it wraps to 0 and ch_frame_done[grant] pulses.
  - rr_ptr = grant+1 mod CH_NUM; return to IDLE.
  - Minimum back-to-back burst spacing: 4 cycles of overhead plus data.
- Beat overrun: beats past BURST_LEN without rlast are still written; beat_cnt saturates at 255; burst_err is set.
- ch_frame_sync[i]:
  - If i is not the active grant: burst_cnt[i]=0 on the next cycle.
  - If i is granted and not IDLE: sync_pending[i] is set and applied in DONE, overriding the increment or wrap. No frame_done pulses unless the wrap condition also held.
  - Sync and wrap in the same cycle: counter ends at 0 and frame_done still pulses.
- Request from the currently granted channel held high is not re-served until other requesters have been served (fairness).
- ch_wr_en is never asserted outside DATA (plus 1 registered trailing cycle).

Test Plan:
- Single channel: rst high 2 cycles, ch_rd_req=5'b00001, arready after 2 cycles, 16 rvalid beats with rlast on beat 16. Expect araddr=0x0000000, arlen=15, exactly 16 ch_wr_en[0] pulses carrying the beat data 1 cycle later, burst_err=0. Second burst araddr=0x0000200.
- Round-robin: ch_rd_req=5'b11111 held for 6 bursts. Expect grant order 0,1,2,3,4,0 and araddr for ch2 = 0x0800000.
- Frame wrap: preload ch1 by running FRAME_BURSTS=4 (override parameter). After the 4th burst, expect ch_frame_done[1] 1-cycle pulse and the next ch1 address = 0x0400000.
- Sync mid-burst: pulse ch_frame_sync[0] during ch0 DATA when burst_cnt=2. Expect that burst to complete normally and the next ch0 araddr=0x0000000. A sync on idle ch3 clears its counter immediately.
- Early rlast: rlast on beat 10. Expect 10 writes, burst_err=1 sticky until rst, FSM back to IDLE.
- Reset mid-burst: assert rst at beat 5. Expect all outputs 0 next cycle, counters 0, and the first post-reset araddr=0x0000000.

Source files
------------

// File: rtl/axi_interconnect_rd.sv
// Read-side AXI interconnect: round-robin arbitration of burst read requests
// from CH_NUM display channels, one AXI read burst per grant, returned beats
// steered into the granted channel's FIFO, per-channel frame address pointers.
module axi_interconnect_rd #(
    parameter int          CH_NUM       = 5,
    parameter int          DATA_W       = 256,
    parameter int          ADDR_W       = 28,
    parameter int          BURST_LEN    = 16,
    parameter int unsigned CH_BASE_STEP = 32'h0400000,
    parameter int          FRAME_BURSTS = 8100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_NUM-1:0]    ch_rd_req,
    input  logic [CH_NUM-1:0]    ch_frame_sync,
    output logic [CH_NUM-1:0]    ch_wr_en,
    output logic [DATA_W-1:0]    ch_wr_data,
    output logic [CH_NUM-1:0]    ch_frame_done,
    output logic [ADDR_W-1:0]    axi_araddr,
    output logic [7:0]           axi_arlen,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic [DATA_W-1:0]    axi_rdata,
    input  logic                 axi_rvalid,
    input  logic                 axi_rlast,
    output logic                 axi_rready,
    output logic                 busy,
    output logic                 burst_err
);

    localparam int GW          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CW          = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;

    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DONE} state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       rr_ptr;
    logic [CW-1:0]       burst_cnt [CH_NUM];
    logic [CH_NUM-1:0]   sync_pending;
    logic [7:0]          beat_cnt;

    logic                arb_found;
    logic [GW-1:0]       arb_grant;
    int                  arb_dist;
    int                  arb_best;
    logic [CH_NUM-1:0]   active_mask;

    // Frame-buffer byte address of burst number cnt of channel ch (wraps at ADDR_W).
    function automatic logic [ADDR_W-1:0] burst_addr(input logic [GW-1:0] ch,
                                                     input logic [CW-1:0] cnt);
        return ADDR_W'(ch) * ADDR_W'(CH_BASE_STEP) + ADDR_W'(cnt) * ADDR_W'(BURST_BYTES);
    endfunction

    assign axi_arlen = 8'(BURST_LEN - 1);
    assign busy      = (state != IDLE);

    // Round-robin pick: requester with smallest circular distance from rr_ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_grant = '0;
        arb_dist  = 0;
        arb_best  = CH_NUM;
        for (int i = 0; i < CH_NUM; i++) begin
            arb_dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + CH_NUM - int'(rr_ptr));
            if (ch_rd_req[i] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                arb_grant = GW'(i);
                arb_found = 1'b1;
            end
        end
    end

    // Channels whose frame sync must be deferred to DONE (owner of the current burst).
    always_comb begin
        active_mask = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if ((state == ADDR || state == DATA || state == DONE) && grant == GW'(i))
                active_mask[i] = 1'b1;
            if (state == ARB && arb_found && arb_grant == GW'(i))
                active_mask[i] = 1'b1;
        end
    end

    // Burst FSM with registered AXI handshakes, FIFO steering and frame pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            sync_pending  <= '0;
            beat_cnt      <= '0;
            axi_araddr    <= '0;
            axi_arvalid   <= 1'b0;
            axi_rready    <= 1'b0;
            ch_wr_en      <= '0;
            ch_wr_data    <= '0;
            ch_frame_done <= '0;
            burst_err     <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) burst_cnt[i] <= '0;
        end else begin
            ch_wr_en      <= '0;
            ch_frame_done <= '0;

            // Idle channels restart at once; the channel being served restarts at DONE.
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_frame_sync[i]) begin
                    if (active_mask[i]) sync_pending[i] <= 1'b1;
                    else                burst_cnt[i]    <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (|ch_rd_req) state <= ARB;
                end
                ARB: begin
                    if (arb_found) begin
                        grant       <= arb_grant;
                        axi_araddr  <= burst_addr(arb_grant, burst_cnt[arb_grant]);
                        axi_arvalid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (axi_rvalid) begin
                        ch_wr_en   <= CH_NUM'(1) << grant;
                        ch_wr_data <= axi_rdata;
                        if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt >= 8'(BURST_LEN)) burst_err <= 1'b1;
                        if (axi_rlast) begin
                            axi_rready <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (beat_cnt != 8'(BURST_LEN)) burst_err <= 1'b1;
                    if (burst_cnt[grant] == CW'(FRAME_BURSTS - 1))
                        ch_frame_done <= CH_NUM'(1) << grant;
                    if (burst_cnt[grant] == CW'(FRAME_BURSTS - 1) ||
                        sync_pending[grant] || ch_frame_sync[grant])
                        burst_cnt[grant] <= '0;
                    else
                        burst_cnt[grant] <= burst_cnt[grant] + CW'(1);
                    sync_pending[grant] <= 1'b0;
                    rr_ptr <= (grant == GW'(CH_NUM - 1)) ? '0 : grant + GW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
